// File: rtl/filter_pkg.sv
// Shared types and constants for the per-voice biquad filter stage.
// Coefficients are Q2.14; unity gain is 1 << 14.
package filter_pkg;

  localparam int COEFF_FRAC_BITS = 14;
  localparam int COEFF_UNITY     = 16384;
  localparam int NUM_COEFFS      = 5;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [2:0] {
    COEFF_B0 = 3'd0,
    COEFF_B1 = 3'd1,
    COEFF_B2 = 3'd2,
    COEFF_A1 = 3'd3,
    COEFF_A2 = 3'd4
  } coeff_sel_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } filt_state_t;

endpackage

// File: rtl/filter_voice_ram.sv
// Simple dual-port voice RAM: one write port, one synchronous read port.
// A same-address read and write in one cycle returns the old word.
module filter_voice_ram #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_Clock,
  input  logic             i_WriteEnable,
  input  logic [AW-1:0]    i_WriteAddr,
  input  logic [WIDTH-1:0] i_WriteData,
  input  logic [AW-1:0]    i_ReadAddr,
  output logic [WIDTH-1:0] o_ReadData
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_Clock) begin
    if (i_WriteEnable) mem[i_WriteAddr] <= i_WriteData;
    o_ReadData <= mem[i_ReadAddr];
  end

endmodule

// File: rtl/filter_biquad_stage.sv
// Time-multiplexed direct-form-I biquad, one voice per clock, 4-stage pipe.
// Define FILTER_SATURATE_EN to clamp the result; otherwise it wraps.
module filter_biquad_stage
  import filter_pkg::*;
#(
  parameter  int NUM_VOICES      = 256,
  parameter  int COEFF_FRAC_BITS = 14,
  localparam int AW              = $clog2(NUM_VOICES)
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  output logic          o_Ready,
  input  logic          i_SampleValid,
  input  logic [AW-1:0] i_VoiceIndex,
  input  sample_t       i_FilterDataIn [3],
  input  logic          i_CoeffWriteEnable,
  input  logic [AW-1:0] i_CoeffWriteVoice,
  input  logic [2:0]    i_CoeffWriteSelect,
  input  sample_t       i_CoeffWriteData,
  output logic          o_SampleValid,
  output logic [AW-1:0] o_VoiceIndex,
  output sample_t       o_FilterDataOut
);

  localparam logic signed [34:0] RND =
    35'sd1 <<< (COEFF_FRAC_BITS - 1);

  filt_state_t   state_q, state_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          clr_we;
  logic          run;
  logic          accept;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    clr_we  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        clr_we  = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == AW'(NUM_VOICES - 1)) state_d = ST_RUN;
      end
      ST_RUN: ;
    endcase
  end

  assign run     = (state_q == ST_RUN);
  assign o_Ready = run;
  assign accept  = i_SampleValid & run;

  logic    [4:0] coef_hit;
  sample_t       coef_rd [NUM_COEFFS];
  sample_t       y1_rd, y2_rd;

  assign coef_hit = (i_CoeffWriteSelect < 3'd5) ?
                    (5'd1 << i_CoeffWriteSelect) : 5'd0;

  for (genvar k = 0; k < NUM_COEFFS; k++) begin : g_coef
    sample_t wdata;
    logic    we;
    assign wdata = clr_we ?
      ((k == int'(COEFF_B0)) ? sample_t'(COEFF_UNITY) : '0) :
      i_CoeffWriteData;
    assign we = i_Reset_n &
      (clr_we | (run & i_CoeffWriteEnable & coef_hit[k]));
    filter_voice_ram #(.WIDTH(16), .DEPTH(NUM_VOICES)) u_ram (
      .i_Clock      (i_Clock),
      .i_WriteEnable(we),
      .i_WriteAddr  (clr_we ? sweep_q : i_CoeffWriteVoice),
      .i_WriteData  (wdata),
      .i_ReadAddr   (i_VoiceIndex),
      .o_ReadData   (coef_rd[k])
    );
  end

  logic                s0_valid, s1_valid, s2_valid;
  logic [AW-1:0]       s0_voice, s1_voice, s2_voice;
  sample_t             s0_x [3];
  logic signed [31:0]  s1_p [NUM_COEFFS];
  sample_t             s1_y1, s2_y1;
  logic signed [34:0]  s2_acc;
  logic signed [34:0]  sh;
  sample_t             y_new;
  logic                hist_we;
  logic [AW-1:0]       hist_addr;

  assign hist_we   = i_Reset_n & (clr_we | s2_valid);
  assign hist_addr = clr_we ? sweep_q : s2_voice;

  // y2 takes the y1 that was read alongside this sample in S0
  filter_voice_ram #(.WIDTH(16), .DEPTH(NUM_VOICES)) u_hist_y1 (
    .i_Clock      (i_Clock),
    .i_WriteEnable(hist_we),
    .i_WriteAddr  (hist_addr),
    .i_WriteData  (clr_we ? '0 : y_new),
    .i_ReadAddr   (i_VoiceIndex),
    .o_ReadData   (y1_rd)
  );

  filter_voice_ram #(.WIDTH(16), .DEPTH(NUM_VOICES)) u_hist_y2 (
    .i_Clock      (i_Clock),
    .i_WriteEnable(hist_we),
    .i_WriteAddr  (hist_addr),
    .i_WriteData  (clr_we ? '0 : s2_y1),
    .i_ReadAddr   (i_VoiceIndex),
    .o_ReadData   (y2_rd)
  );

  always_ff @(posedge i_Clock) begin
    s0_voice <= i_VoiceIndex;
    s0_x     <= i_FilterDataIn;
    s1_voice <= s0_voice;
    s1_y1    <= y1_rd;
    s1_p[0]  <= coef_rd[0] * s0_x[0];
    s1_p[1]  <= coef_rd[1] * s0_x[1];
    s1_p[2]  <= coef_rd[2] * s0_x[2];
    s1_p[3]  <= coef_rd[3] * y1_rd;
    s1_p[4]  <= coef_rd[4] * y2_rd;
    s2_voice <= s1_voice;
    s2_y1    <= s1_y1;
    s2_acc   <= 35'(s1_p[0]) + 35'(s1_p[1]) + 35'(s1_p[2])
              - 35'(s1_p[3]) - 35'(s1_p[4]);
  end

  always_comb begin
    sh = (s2_acc + RND) >>> COEFF_FRAC_BITS;
`ifdef FILTER_SATURATE_EN
    if (sh > 35'sd32767)       y_new = 16'sh7fff;
    else if (sh < -35'sd32768) y_new = 16'sh8000;
    else                       y_new = sample_t'(sh);
`else
    y_new = sample_t'(sh);
`endif
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      s0_valid        <= 1'b0;
      s1_valid        <= 1'b0;
      s2_valid        <= 1'b0;
      o_SampleValid   <= 1'b0;
      o_VoiceIndex    <= '0;
      o_FilterDataOut <= '0;
    end else begin
      s0_valid      <= accept;
      s1_valid      <= s0_valid;
      s2_valid      <= s1_valid;
      o_SampleValid <= s2_valid;
      if (s2_valid) begin
        o_VoiceIndex    <= s2_voice;
        o_FilterDataOut <= y_new;
      end
    end
  end

  // history is not forwarded: a voice may not re-enter within 3 cycles
  always_ff @(posedge i_Clock) begin
    if (i_Reset_n && accept) begin
      assert (!((s0_valid && s0_voice == i_VoiceIndex) ||
                (s1_valid && s1_voice == i_VoiceIndex) ||
                (s2_valid && s2_voice == i_VoiceIndex)));
    end
  end

endmodule

// File: tb/tb_filter_biquad_stage.sv
// Self-checking bench for filter_biquad_stage with a per-voice
// arithmetic reference model; honours FILTER_SATURATE_EN.
module tb_filter_biquad_stage;
  import filter_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ready;
  logic       in_valid;
  logic [7:0] in_voice;
  sample_t    x_in [3];
  logic       cwe;
  logic [7:0] cvoice;
  logic [2:0] csel;
  sample_t    cdata;
  logic       out_valid;
  logic [7:0] out_voice;
  sample_t    out_y;

  filter_biquad_stage dut (
    .i_Clock           (clk),
    .i_Reset_n         (rst_n),
    .o_Ready           (ready),
    .i_SampleValid     (in_valid),
    .i_VoiceIndex      (in_voice),
    .i_FilterDataIn    (x_in),
    .i_CoeffWriteEnable(cwe),
    .i_CoeffWriteVoice (cvoice),
    .i_CoeffWriteSelect(csel),
    .i_CoeffWriteData  (cdata),
    .o_SampleValid     (out_valid),
    .o_VoiceIndex      (out_voice),
    .o_FilterDataOut   (out_y)
  );

  typedef struct {
    bit v;
    int voice;
    int y;
  } exp_t;

  int   n_cmp = 0;
  int   n_mis = 0;
  exp_t pipe [4];
  int   mb [5][256];
  int   hy1 [256];
  int   hy2 [256];
  bit   model_run;
  int   sweep;
  bit   seen;
  int   obs_y;
  int   obs_cnt;
  int   cyc;
  int   last_sent [256];
  int   rec_exp [4] = '{1000, 500, 250, 125};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_mis++;
      $error("FAIL %s got %0h want %0h at cycle %0d",
             tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 256; v++) begin
      mb[0][v] = 16384;
      for (int k = 1; k < 5; k++) mb[k][v] = 0;
      hy1[v] = 0;
      hy2[v] = 0;
    end
    for (int i = 0; i < 4; i++) pipe[i] = '{0, 0, 0};
    model_run = 0;
    sweep     = 0;
    seen      = 0;
  endtask

  function automatic int ref_y(int v, int x0, int x1, int x2);
    longint acc;
    longint q;
    int     y;
    acc = longint'(mb[0][v]) * x0 + longint'(mb[1][v]) * x1
        + longint'(mb[2][v]) * x2 - longint'(mb[3][v]) * hy1[v]
        - longint'(mb[4][v]) * hy2[v] + 64'sd8192;
    q = acc >>> 14;
`ifdef FILTER_SATURATE_EN
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    y = int'(q);
`else
    y = int'(shortint'(q));
`endif
    hy2[v] = hy1[v];
    hy1[v] = y;
    return y;
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    cwe      = 1'b0;
  endtask

  task automatic send(input int v, input int a, input int b,
                      input int c);
    in_valid = 1'b1;
    in_voice = 8'(v);
    x_in[0]  = sample_t'(a);
    x_in[1]  = sample_t'(b);
    x_in[2]  = sample_t'(c);
  endtask

  task automatic wcoef(input int v, input int s, input int d);
    cwe    = 1'b1;
    cvoice = 8'(v);
    csel   = 3'(s);
    cdata  = sample_t'(d);
  endtask

  task automatic tick();
    exp_t cur;
    cur = '{0, 0, 0};
    if (!rst_n) begin
      model_reset();
    end else begin
      if (model_run && in_valid) begin
        cur.v     = 1;
        cur.voice = int'(in_voice);
        cur.y     = ref_y(cur.voice, int'(x_in[0]),
                          int'(x_in[1]), int'(x_in[2]));
        last_sent[cur.voice] = cyc;
      end
      if (model_run && cwe && csel < 3'd5)
        mb[int'(csel)][int'(cvoice)] = int'(cdata);
      if (!model_run) begin
        sweep++;
        if (sweep == 256) model_run = 1;
      end
    end
    pipe[3] = pipe[2];
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = cur;
    @(posedge clk);
    #1;
    cyc++;
    chk("ready", 32'(ready), 32'(model_run));
    chk("valid", 32'(out_valid), 32'(pipe[3].v));
    if (pipe[3].v) begin
      chk("voice", 32'(out_voice), pipe[3].voice);
      chk("y", {{16{out_y[15]}}, out_y}, pipe[3].y);
      seen  = 1;
      obs_y = int'(out_y);
      obs_cnt++;
    end else if (!seen) begin
      chk("rst_voice", 32'(out_voice), 32'd0);
      chk("rst_y", {{16{out_y[15]}}, out_y}, 32'd0);
    end
  endtask

  task automatic sweep_wait();
    idle();
    repeat (256) tick();
    chk("ready_up", 32'(ready), 32'd1);
  endtask

  initial begin
    int v;
    bit ok;
    int cnt0;
    for (int i = 0; i < 256; i++) last_sent[i] = -100;
    cyc      = 0;
    obs_cnt  = 0;
    obs_y    = 0;
    rst_n    = 1'b0;
    in_voice = '0;
    cvoice   = '0;
    csel     = '0;
    cdata    = '0;
    for (int i = 0; i < 3; i++) x_in[i] = '0;
    idle();
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (255) tick();
    chk("ready_lo_255", 32'(ready), 32'd0);
    tick();
    chk("ready_hi_256", 32'(ready), 32'd1);

    // select 6 is ignored, so voice 5 stays at unity gain
    wcoef(5, 6, 0);
    tick();
    idle();
    send(5, 1000, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    chk("pass_y", obs_y, 1000);
    chk("pass_cnt", obs_cnt, 1);

    wcoef(3, 0, 8192);
    tick();
    idle();
    send(3, -2000, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    chk("gain_neg", obs_y, -1000);
    send(3, 3, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    chk("gain_rnd", obs_y, 2);

    wcoef(7, 3, -8192);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      send(7, (k == 0) ? 1000 : 0, 0, 0);
      tick();
      idle();
      repeat (7) tick();
      chk("recur", obs_y, rec_exp[k]);
    end

    wcoef(9, 0, 32767);
    tick();
    wcoef(9, 1, 32767);
    tick();
    idle();
    send(9, 32767, 32767, 0);
    tick();
    idle();
    repeat (3) tick();
`ifdef FILTER_SATURATE_EN
    chk("ovf", obs_y, 32767);
`else
    chk("ovf", obs_y, -8);
`endif

    wcoef(2, 0, 0);
    send(2, 500, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    chk("collide_old", obs_y, 500);
    send(2, 500, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    chk("collide_new", obs_y, 0);

    cnt0 = obs_cnt;
    send(4, 123, 0, 0);
    tick();
    send(6, 321, 0, 0);
    tick();
    idle();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("flush_cnt", obs_cnt, cnt0);
    sweep_wait();
    send(2, 77, 0, 0);
    tick();
    idle();
    repeat (3) tick();
    chk("post_rst", obs_y, 77);

    for (int it = 0; it < 600; it++) begin
      idle();
      if ($urandom_range(0, 3) != 0) begin
        ok = 0;
        v  = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
          v = int'($urandom_range(0, 255));
          if (cyc - last_sent[v] >= 4) ok = 1;
        end
        if (ok) send(v, int'($urandom & 16'hffff),
                     int'($urandom & 16'hffff),
                     int'($urandom & 16'hffff));
      end
      if ($urandom_range(0, 4) == 0)
        wcoef(int'($urandom_range(0, 255)),
              int'($urandom_range(0, 7)),
              int'($urandom & 16'hffff));
      tick();
    end
    idle();
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
